// File: rtl/user_logic_signal_proc.sv
// user_logic_signal_proc
// Range-gated pulse-energy accumulator for the ADQ214 user-logic slot.
// After each accepted trigger, sums x0^2 + x0z^2 into up to 16 consecutive
// range bins. This repeats over nACC_Pulses pulses, and then one 64-bit
// result per bin is streamed out with a valid strobe.
//
// Ports
//   clk_i, rst_i            : sample clock, async active-low reset
//   x0_i, x0z_i             : signed sample pair (x0_i earlier)
//   x1_i, x1z_i             : unused
//   trigger_vector_i        : trigger strobes
//   user_register_i [127:0] : EndPosition | MirrorStart | nOverlap | nRangeBins |
//                             nPoints_RB | nACC_Pulses | TriggerLevel | CMD
//   y0_o..y1z_o             : {y0,y0z,y1,y1z} = 64-bit bin energy, 0 when idle
//   trigger_vector_o        : trigger_vector_i delayed one clock
//   data_valid_o            : result strobe
//   user_register_o [63:0]  : pulse count | frame count | state code | CMD echo
//   ul_partnum_*_o          : part-number constants
//
// state   | meaning
// IDLE    | waiting for a trigger (only accepted with CMD[0]=1)
// ACQ     | counting positions after the trigger, accumulating bin energy
// READOUT | streaming acc[0..nRangeBins-1], one per clock

module user_logic_signal_proc (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [15:0]  x0_i,
  input  logic [15:0]  x0z_i,
  input  logic [15:0]  x1_i,
  input  logic [15:0]  x1z_i,
  input  logic [3:0]   trigger_vector_i,
  input  logic [127:0] user_register_i,
  output logic [15:0]  y0_o,
  output logic [15:0]  y0z_o,
  output logic [15:0]  y1_o,
  output logic [15:0]  y1z_o,
  output logic [3:0]   trigger_vector_o,
  output logic         data_valid_o,
  output logic [63:0]  user_register_o,
  output logic [15:0]  ul_partnum_1_o,
  output logic [15:0]  ul_partnum_2_o,
  output logic [15:0]  ul_partnum_3_o,
  output logic [15:0]  ul_partnum_rev_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQ     = 2'd1,
    ST_READOUT = 2'd2
  } state_t;

  localparam int N_BINS = 16;

  // reset synchronizer: assertion is immediate, release is aligned to clk_i
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // register field decode
  logic [15:0] end_pos, mirror_start, nbins_raw, npts_raw, nacc_raw, cmd;
  logic [4:0]  nbins_eff;
  logic [15:0] npts_eff, nacc_eff;
  logic        en;

  assign end_pos      = user_register_i[127:112];
  assign mirror_start = user_register_i[111:96];
  assign nbins_raw    = user_register_i[79:64];
  assign npts_raw     = user_register_i[63:48];
  assign nacc_raw     = user_register_i[47:32];
  assign cmd          = user_register_i[15:0];
  assign en           = cmd[0];

  always_comb begin
    if (nbins_raw == 16'd0)       nbins_eff = 5'd1;
    else if (nbins_raw > 16'd16)  nbins_eff = 5'd16;
    else                          nbins_eff = nbins_raw[4:0];
    npts_eff = (npts_raw == 16'd0) ? 16'd1 : npts_raw;
    nacc_eff = (nacc_raw == 16'd0) ? 16'd1 : nacc_raw;
  end

  logic unused_inputs;
  assign unused_inputs = ^{x1_i, x1z_i, user_register_i[95:80], user_register_i[31:16]};

  // state and counters
  state_t      state_q, state_d;
  logic [16:0] c_q, c_d;
  logic [15:0] pulse_q, pulse_d;
  logic [15:0] frame_q, frame_d;
  logic [3:0]  rd_q, rd_d;
  logic [15:0] cmd_q;
  logic [3:0]  trig_q;
  logic        dv_q, dv_d;
  logic [63:0] res_q, res_d;
  logic        clr_acc;

  // energy pipeline stage
  logic [32:0] e_q, e_d;
  logic        e_vld_q, e_vld_d;
  logic [3:0]  bin_q, bin_d;

  logic [63:0] acc_q [N_BINS];
  logic [63:0] acc_d [N_BINS];

  // bin lookup for the current position; bin boundaries can exceed 16 bits
  // (MirrorStart + 16 * nPoints_RB), so the compare runs at 22 bits
  logic [21:0] c_ext, lo, hi, last_end, pulse_end;
  logic        hit;

  assign c_ext = {5'd0, c_q};

  always_comb begin
    hit      = 1'b0;
    bin_d    = 4'd0;
    last_end = 22'd0;
    lo       = {6'd0, mirror_start};
    hi       = 22'd0;
    for (int k = 0; k < N_BINS; k++) begin
      hi = lo + {6'd0, npts_eff};
      if ((5'(k) < nbins_eff) && !hit && (c_ext >= lo) && (c_ext < hi)) begin
        hit   = 1'b1;
        bin_d = 4'(k);
      end
      if (5'(k) == nbins_eff - 5'd1) last_end = hi;
      lo = hi;
    end
    pulse_end = (last_end < {6'd0, end_pos}) ? last_end : {6'd0, end_pos};
  end

  logic pulse_done;
  assign pulse_done = (c_ext >= pulse_end);

  // squares are non-negative, so the 33-bit sum is taken as unsigned
  logic signed [31:0] sq0, sq1;
  assign sq0 = $signed(x0_i) * $signed(x0_i);
  assign sq1 = $signed(x0z_i) * $signed(x0z_i);

  always_comb begin
    e_d     = {1'b0, sq0} + {1'b0, sq1};
    e_vld_d = (state_q == ST_ACQ) && en && hit && !pulse_done &&
              (c_q < {1'b0, end_pos});
  end

  // next-state and outputs
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    pulse_d = pulse_q;
    frame_d = frame_q;
    rd_d    = rd_q;
    clr_acc = 1'b0;
    dv_d    = 1'b0;
    res_d   = 64'd0;
    if (!en) begin
      // disable aborts whatever is in progress, with no output
      state_d = ST_IDLE;
      pulse_d = 16'd0;
      clr_acc = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|trigger_vector_i) begin
            state_d = ST_ACQ;
            c_d     = 17'd0;
          end
        end
        ST_ACQ: begin
          // the last sample's add lands on this same edge, so the
          // accumulators are complete by the time READOUT reads them
          if (pulse_done) begin
            pulse_d = pulse_q + 16'd1;
            if ({1'b0, pulse_q} + 17'd1 >= {1'b0, nacc_eff}) begin
              state_d = ST_READOUT;
              rd_d    = 4'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            c_d = c_q + 17'd1;
          end
        end
        ST_READOUT: begin
          dv_d  = 1'b1;
          res_d = acc_q[rd_q];
          if ({1'b0, rd_q} >= nbins_eff - 5'd1) begin
            state_d = ST_IDLE;
            pulse_d = 16'd0;
            frame_d = frame_q + 16'd1;
            clr_acc = 1'b1;
          end else begin
            rd_d = rd_q + 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < N_BINS; k++) begin
      acc_d[k] = clr_acc ? 64'd0 : acc_q[k];
    end
    if (!clr_acc && e_vld_q) begin
      acc_d[bin_q] = acc_q[bin_q] + {31'd0, e_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= 17'd0;
      pulse_q <= 16'd0;
      frame_q <= 16'd0;
      rd_q    <= 4'd0;
      cmd_q   <= 16'd0;
      trig_q  <= 4'd0;
      dv_q    <= 1'b0;
      res_q   <= 64'd0;
      e_q     <= 33'd0;
      e_vld_q <= 1'b0;
      bin_q   <= 4'd0;
      for (int k = 0; k < N_BINS; k++) acc_q[k] <= 64'd0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      pulse_q <= pulse_d;
      frame_q <= frame_d;
      rd_q    <= rd_d;
      cmd_q   <= cmd;
      trig_q  <= trigger_vector_i;
      dv_q    <= dv_d;
      res_q   <= res_d;
      e_q     <= e_d;
      e_vld_q <= e_vld_d;
      bin_q   <= bin_d;
      for (int k = 0; k < N_BINS; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign {y0_o, y0z_o, y1_o, y1z_o} = res_q;
  assign data_valid_o     = dv_q;
  assign trigger_vector_o = trig_q;
  assign user_register_o  = {pulse_q, frame_q, 14'd0, state_q, cmd_q};

  assign ul_partnum_1_o   = 16'h4343;
  assign ul_partnum_2_o   = 16'h444C;
  assign ul_partnum_3_o   = 16'h0214;
  assign ul_partnum_rev_o = 16'h0001;

endmodule

// File: tb/tb_user_logic_signal_proc.sv
module tb_user_logic_signal_proc;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [15:0]  x0_i, x0z_i, x1_i, x1z_i;
  logic [3:0]   trigger_vector_i;
  logic [127:0] user_register_i;
  logic [15:0]  y0_o, y0z_o, y1_o, y1z_o;
  logic [3:0]   trigger_vector_o;
  logic         data_valid_o;
  logic [63:0]  user_register_o;
  logic [15:0]  p1, p2, p3, prev;

  user_logic_signal_proc dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .x0_i             (x0_i),
    .x0z_i            (x0z_i),
    .x1_i             (x1_i),
    .x1z_i            (x1z_i),
    .trigger_vector_i (trigger_vector_i),
    .user_register_i  (user_register_i),
    .y0_o             (y0_o),
    .y0z_o            (y0z_o),
    .y1_o             (y1_o),
    .y1z_o            (y1z_o),
    .trigger_vector_o (trigger_vector_o),
    .data_valid_o     (data_valid_o),
    .user_register_o  (user_register_o),
    .ul_partnum_1_o   (p1),
    .ul_partnum_2_o   (p2),
    .ul_partnum_3_o   (p3),
    .ul_partnum_rev_o (prev)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] y_all;
  logic [15:0] st_pulse, st_frame, st_state;
  assign y_all    = {y0_o, y0z_o, y1_o, y1z_o};
  assign st_pulse = user_register_o[63:48];
  assign st_frame = user_register_o[47:32];
  assign st_state = user_register_o[31:16];

  // strobe recorder
  logic [63:0] sbuf [64];
  int          sat  [64];
  int          sc  = 0;
  int          cyc = 0;

  always @(negedge clk_i) begin
    cyc++;
    if (data_valid_o && sc < 64) begin
      sbuf[sc] = y_all;
      sat[sc]  = cyc;
      sc++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_regs(input logic [15:0] endp, input logic [15:0] ms,
                          input logic [15:0] nb, input logic [15:0] np,
                          input logic [15:0] na, input logic [15:0] cmd);
    user_register_i = {endp, ms, 16'd0, nb, np, na, 16'd0, cmd};
  endtask

  task automatic fire(input logic [3:0] t);
    trigger_vector_i = t;
    tick();
    trigger_vector_i = 4'd0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (st_state == 16'd0) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, {63'd0, done}, 64'd1);
    ticks(3);
  endtask

  int s0;
  logic seen;

  initial begin
    rst_i            = 1'b0;
    x0_i             = 16'd0;
    x0z_i            = 16'd0;
    x1_i             = 16'd0;
    x1z_i            = 16'd0;
    trigger_vector_i = 4'd0;
    set_regs(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    ticks(3);

    // reset state
    check("rst_dv", {63'd0, data_valid_o}, 64'd0);
    check("rst_y", y_all, 64'd0);
    check("rst_status", user_register_o, 64'd0);
    check("rst_trig", {60'd0, trigger_vector_o}, 64'd0);
    check("partnum", {p1, p2, p3, prev}, 64'h4343_444C_0214_0001);

    rst_i = 1'b1;
    ticks(4);

    // disabled trigger: trigger is delayed but no state change
    set_regs(16'd1680, 16'd430, 16'd7, 16'd250, 16'd2, 16'd0);
    s0 = sc;
    trigger_vector_i = 4'b0001;
    tick();
    trigger_vector_i = 4'b0000;
    check("trig_delay", {60'd0, trigger_vector_o}, 64'd1);
    tick();
    check("trig_clear", {60'd0, trigger_vector_o}, 64'd0);
    ticks(20);
    check("dis_state", {48'd0, st_state}, 64'd0);
    check("dis_pulse", {48'd0, st_pulse}, 64'd0);
    check("dis_strobes", 64'(sc - s0), 64'd0);

    // baseline: 2 pulses, 7 bins, bins 5-6 past EndPosition
    x0_i  = 16'd100;
    x0z_i = 16'd100;
    set_regs(16'd1680, 16'd430, 16'd7, 16'd250, 16'd2, 16'd1);
    ticks(2);
    s0 = sc;
    fire(4'b0100);
    check("base_acq", {48'd0, st_state}, 64'd1);
    wait_idle("base_p1_timeout", 3000);
    check("base_pulse1", {48'd0, st_pulse}, 64'd1);
    ticks(20);
    fire(4'b0100);
    wait_idle("base_p2_timeout", 3000);
    check("base_strobes", 64'(sc - s0), 64'd7);
    if (sc - s0 == 7) begin
      for (int i = 0; i < 7; i++)
        check($sformatf("base_bin%0d", i), sbuf[s0 + i], (i < 5) ? 64'd10000000 : 64'd0);
      check("base_contig", 64'(sat[s0 + 6] - sat[s0]), 64'd6);
    end
    check("base_frame", {48'd0, st_frame}, 64'd1);
    check("base_pulse_clr", {48'd0, st_pulse}, 64'd0);
    check("base_y_idle", y_all, 64'd0);

    // single pulse, negative samples: e = 9 + 16 = 25, 10 points per bin
    x0_i  = -16'sd3;
    x0z_i = 16'sd4;
    set_regs(16'd1680, 16'd5, 16'd2, 16'd10, 16'd1, 16'd1);
    ticks(2);
    s0 = sc;
    fire(4'b1000);
    wait_idle("neg_timeout", 200);
    check("neg_strobes", 64'(sc - s0), 64'd2);
    check("neg_bin0", sbuf[s0], 64'd250);
    check("neg_bin1", sbuf[s0 + 1], 64'd250);
    check("neg_frame", {48'd0, st_frame}, 64'd2);

    // trigger during ACQ is ignored
    set_regs(16'd1680, 16'd5, 16'd2, 16'd10, 16'd2, 16'd1);
    ticks(2);
    s0 = sc;
    fire(4'b0001);
    ticks(3);
    check("ign_in_acq", {48'd0, st_state}, 64'd1);
    fire(4'b0001);
    wait_idle("ign_timeout", 200);
    check("ign_pulse", {48'd0, st_pulse}, 64'd1);
    check("ign_strobes", 64'(sc - s0), 64'd0);

    // disable mid-frame, re-enable: one 2-pulse frame
    set_regs(16'd1680, 16'd5, 16'd2, 16'd10, 16'd2, 16'd0);
    ticks(3);
    check("abort_pulse", {48'd0, st_pulse}, 64'd0);
    set_regs(16'd1680, 16'd5, 16'd2, 16'd10, 16'd2, 16'd1);
    ticks(2);
    fire(4'b0010);
    wait_idle("reen_p1_timeout", 200);
    fire(4'b0010);
    wait_idle("reen_p2_timeout", 200);
    check("reen_strobes", 64'(sc - s0), 64'd2);
    check("reen_bin0", sbuf[s0], 64'd500);
    check("reen_bin1", sbuf[s0 + 1], 64'd500);
    check("reen_frame", {48'd0, st_frame}, 64'd3);

    // async reset during READOUT; nRangeBins=20 clamps to 16
    set_regs(16'd100, 16'd0, 16'd20, 16'd1, 16'd1, 16'd1);
    ticks(2);
    fire(4'b0001);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (data_valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("ar_readout_seen", {63'd0, seen}, 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_dv", {63'd0, data_valid_o}, 64'd0);
    check("ar_status", user_register_o, 64'd0);
    check("ar_y", y_all, 64'd0);
    ticks(2);
    rst_i = 1'b1;
    ticks(4);
    s0 = sc;
    fire(4'b0001);
    wait_idle("ar_timeout", 200);
    check("ar_strobes", 64'(sc - s0), 64'd16);
    if (sc - s0 == 16) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("ar_bin%0d", i), sbuf[s0 + i], 64'd25);
    end
    check("ar_frame", {48'd0, st_frame}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/user_logic_signal_proc.md
# user_logic_signal_proc

Range-gated pulse-energy accumulator for the ADQ214 user-logic slot (`user_logic_signal_processing`). It sits between the ADC sample stream (two samples per clock) and the host readout path. After each accepted trigger it sums the sample energy in a set of consecutive range bins, accumulates over a programmable number of pulses, then streams one 64-bit result per bin with a valid strobe.

## Interface
- No parameters. Max range bins fixed at 16.
- `clk_i` in 1: sample clock, 200 MHz.
- `rst_i` in 1: asynchronous reset, active-low.
- `x0_i`, `x0z_i` in 16 each: signed sample pair per clock; `x0_i` is the earlier sample.
- `x1_i`, `x1z_i` in 16 each: unused, may float.
- `trigger_vector_i` in 4: trigger strobes, 1 clock wide.
- `user_register_i` in 128: host registers, 16-bit fields:
  - [127:112] EndPosition
  - [111:96] MirrorStart
  - [95:80] nOverlap, reserved
  - [79:64] nRangeBins
  - [63:48] nPoints_RB
  - [47:32] nACC_Pulses
  - [31:16] TriggerLevel, reserved
  - [15:0] CMD; bit0 = enable
- `y0_o`, `y0z_o`, `y1_o`, `y1z_o` out 16 each: bin result, `{y0_o,y0z_o,y1_o,y1z_o}` = 64-bit unsigned energy.
- `trigger_vector_o` out 4: `trigger_vector_i` delayed one clock.
- `data_valid_o` out 1: result strobe.
- `user_register_o` out 64: status word:
  - [63:48] accumulated-pulse count
  - [47:32] completed-frame count, wraps
  - [31:16] state code: IDLE=0, ACQ=1, READOUT=2
  - [15:0] CMD echo
- `ul_partnum_1_o`/`_2_o`/`_3_o`/`_rev_o` out 16 each: constants 16'h4343, 16'h444C, 16'h0214, 16'h0001.

## Operation
- All positions are counted in clocks (sample pairs) after the trigger.
- A trigger is any nonzero `trigger_vector_i` sampled in IDLE with CMD[0]=1. Triggers are ignored when CMD[0]=0, in ACQ, or in READOUT.
- Effective values:
  - nRangeBins: 0 → 1, >16 → 16.
  - nACC_Pulses: 0 → 1.
  - nPoints_RB: 0 → 1.
- **IDLE:** waits for a trigger. On a trigger, clear the position counter c and go to ACQ.
- **ACQ:**
  - c = 0 on the first clock after the trigger-sampling edge, then increments by 1 per clock.
  - Per-clock energy e = x0_i² + x0z_i², computed as signed 16×16 products with an unsigned 33-bit sum.
  - Bin k (0 ≤ k < nRangeBins) owns c in [MirrorStart + k·nPoints_RB, MirrorStart + (k+1)·nPoints_RB).
  - Only samples with c < EndPosition are accumulated.
  - e is added into 64-bit accumulator acc[k]. Accumulators never clear between pulses of one frame.
- **End of pulse:** occurs when c reaches the last bin end or EndPosition, whichever is earlier.
  - Increment the pulse count.
  - If pulse count < nACC_Pulses, return to IDLE, keeping the accumulators.
  - Otherwise go to READOUT.
- **READOUT:**
  - nRangeBins consecutive clocks with `data_valid_o`=1, outputting acc[0] first through acc[nRangeBins−1].
  - Then clear all accumulators and the pulse count, increment the frame count, and go to IDLE.
- **Disable:** CMD[0] falling in any state aborts the frame. Clear accumulators and pulse count, go to IDLE, emit no output.
- **Output idle values:** y outputs are 0 whenever `data_valid_o`=0.
- **Saturation:** none needed. Worst case 2^31 × 65535 × 65535 fits in 64 bits.
- **Register sampling:** register values are read continuously. Changing them mid-frame gives undefined results but must not hang the state machine.

## Timing
- **Reset (async assert, sync release):**
  - All outputs 0 except the part-number constants.
  - State IDLE; accumulators, counters and `trigger_vector_o` cleared.
- **Trigger path:** `trigger_vector_o` has 1-clock latency.
- **Energy path:** sample at position c reaches acc within 2 clocks (square register, then add). The end-of-pulse decision waits for this pipeline to drain.
- **Readout start:** the first `data_valid_o` is asserted ≤ 4 clocks after the end-of-pulse position of the final pulse.
- **Readout strobes:** exactly nRangeBins strobes, back-to-back, no gaps.
- **Re-arm:** a trigger arriving on the same clock as the return to IDLE is ignored. The earliest accepted trigger is one clock later.

## Test plan
- **Baseline:** set EndPosition=1680, MirrorStart=430, nRangeBins=7, nPoints_RB=250, nACC_Pulses=2, CMD=1, constant x0=x0z=100, triggers 0b0100 every 100 µs.
  - After 2 triggers: exactly 7 valid strobes.
  - Bins 0–4 = 10,000,000 each; bins 5–6 = 0 (beyond EndPosition).
- **Disabled trigger:** CMD=0 with trigger 0b0001 → no state change, `data_valid_o` stays 0, pulse count stays 0.
- **Single pulse, negative samples:** nACC_Pulses=1, x0=−3, x0z=4, nRangeBins=2, nPoints_RB=10, MirrorStart=5 → two strobes, each 250.
- **Ignored trigger:** a second trigger during ACQ is ignored → pulse count increments once.
- **Disable mid-frame:** CMD→0 after 1 of 2 pulses, then re-enable and fire 2 triggers → only one frame is output, with 2-pulse values.
- **Async reset:** async reset during READOUT → `data_valid_o` drops immediately, all status fields read 0, next frame is correct.
